// File: rtl/rapcore_cmd_arbiter.sv
// Command scheduler for the rapcore motion core: arbitrates a Wishbone-fed
// command FIFO against the SPI command source and exposes status/control/counters.
module rapcore_cmd_arbiter #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
   input  logic        wb_clk_i,
   input  logic        resetn,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        spi_cmd_valid,
   input  logic [31:0] spi_cmd_data,
   output logic        spi_cmd_ready,
   output logic        core_cmd_valid,
   output logic [31:0] core_cmd_data,
   output logic        core_cmd_src,
   input  logic        core_cmd_ready,
   input  logic        halt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t        state_q;
   logic          ack_q;
   logic [31:0]   dat_q, dat_d;
   logic          en_q, prio_q, ovf_q, last_src_q;
   logic          halt_meta_q, halted_q;
   logic [31:0]   data_q;
   logic          src_q;
   logic [15:0]   wb_cnt_q, spi_cnt_q;
   logic [AW-1:0] wptr_q, rptr_q;
   logic [LW-1:0] level_q, level_ap;
   logic [31:0]   mem_q [FIFO_DEPTH];

   logic          access, acc_new, wr_new, rd_new;
   logic [1:0]    off;
   logic          cmd_wr, status_wr, ctrl_wr, grants_wr, flush, fifo_clr;
   logic          push, ovf_set, pop, load, xfer;
   logic          wb_req, spi_req, grant_spi, grant_wb;
   logic [31:0]   status;
   logic          unused_adr;

   // A new access is only recognised while ack is low, so ack pulses once and then rests.
   assign access    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign acc_new   = access & ~ack_q;
   assign wr_new    = acc_new & wbs_we_i;
   assign rd_new    = acc_new & ~wbs_we_i;
   assign off       = wbs_adr_i[3:2];
   assign unused_adr = ^wbs_adr_i[1:0];

   assign cmd_wr    = wr_new & (off == 2'd0) & (wbs_sel_i == 4'hF);
   assign status_wr = wr_new & (off == 2'd1);
   assign ctrl_wr   = wr_new & (off == 2'd2);
   assign grants_wr = wr_new & (off == 2'd3);
   assign flush     = ctrl_wr & wbs_dat_i[2];
   assign fifo_clr  = flush | halted_q;

   assign wb_req    = (level_q != '0);
   assign spi_req   = spi_cmd_valid;
   assign grant_spi = spi_req & (~wb_req | prio_q | ~last_src_q);
   assign grant_wb  = wb_req & ~grant_spi;
   assign load      = en_q & ~halted_q & (~core_cmd_valid | core_cmd_ready);
   assign pop       = load & grant_wb;
   assign xfer      = core_cmd_valid & core_cmd_ready;

   // Fullness is judged after this cycle's pop so a push into a draining full FIFO survives.
   assign level_ap  = level_q - LW'(pop);
   assign push      = cmd_wr & ~fifo_clr & (level_ap != DEPTH_L);
   assign ovf_set   = cmd_wr & ~fifo_clr & (level_ap == DEPTH_L);

   assign status = {18'd0, core_cmd_valid, last_src_q, halted_q, ovf_q,
                    (level_q == DEPTH_L), (level_q == '0), 8'(level_q)};

   always_comb begin
      dat_d = '0;
      if (rd_new) begin
         case (off)
            2'd1:    dat_d = status;
            2'd2:    dat_d = {30'd0, prio_q, en_q};
            2'd3:    dat_d = {spi_cnt_q, wb_cnt_q};
            default: dat_d = '0;
         endcase
      end
   end

   always_ff @(posedge wb_clk_i or negedge resetn) begin
      if (!resetn) begin
         ack_q     <= 1'b0;
         dat_q     <= '0;
         en_q      <= 1'b0;
         prio_q    <= 1'b0;
         ovf_q     <= 1'b0;
         wb_cnt_q  <= '0;
         spi_cnt_q <= '0;
      end else begin
         ack_q <= acc_new;
         dat_q <= dat_d;
         if (ctrl_wr) begin
            en_q   <= wbs_dat_i[0];
            prio_q <= wbs_dat_i[1];
         end
         if (ovf_set)
            ovf_q <= 1'b1;
         else if (status_wr && wbs_dat_i[10])
            ovf_q <= 1'b0;
         if (grants_wr) begin
            wb_cnt_q  <= '0;
            spi_cnt_q <= '0;
         end else if (xfer) begin
            if (src_q) spi_cnt_q <= spi_cnt_q + 16'd1;
            else       wb_cnt_q  <= wb_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge resetn) begin
      if (!resetn) begin
         halt_meta_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         halt_meta_q <= halt;
         halted_q    <= halt_meta_q;
      end
   end

   always_ff @(posedge wb_clk_i or negedge resetn) begin
      if (!resetn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else if (fifo_clr) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         level_q <= level_ap + LW'(push);
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wptr_q] <= wbs_dat_i;
   end

   always_ff @(posedge wb_clk_i or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         data_q     <= '0;
         src_q      <= 1'b0;
         last_src_q <= 1'b1;
      end else if (halted_q) begin
         state_q <= IDLE;
      end else if (load && (wb_req || spi_req)) begin
         state_q    <= HOLD;
         data_q     <= grant_spi ? spi_cmd_data : mem_q[rptr_q];
         src_q      <= grant_spi;
         last_src_q <= grant_spi;
      end else if (xfer) begin
         state_q <= IDLE;
      end
   end

   assign wbs_ack_o      = ack_q;
   assign wbs_dat_o      = dat_q;
   assign core_cmd_valid = (state_q == HOLD);
   assign core_cmd_data  = data_q;
   assign core_cmd_src   = src_q;
   assign spi_cmd_ready  = load & grant_spi;

endmodule

// File: tb/tb_rapcore_cmd_arbiter.sv
// Directed scoreboard bench for rapcore_cmd_arbiter: expected core transfers and
// Wishbone read data are queued by the stimulus and checked by a monitor.
module tb_rapcore_cmd_arbiter;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam logic [31:0] SPI0 = 32'h5000_0000;

   logic        wb_clk_i, resetn;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        spi_cmd_valid;
   logic [31:0] spi_cmd_data;
   logic        spi_cmd_ready;
   logic        core_cmd_valid;
   logic [31:0] core_cmd_data;
   logic        core_cmd_src;
   logic        core_cmd_ready;
   logic        halt;

   rapcore_cmd_arbiter #(.FIFO_DEPTH(8), .BASE_ADR(BASE)) dut (
      .wb_clk_i(wb_clk_i), .resetn(resetn),
      .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
      .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .spi_cmd_valid(spi_cmd_valid), .spi_cmd_data(spi_cmd_data),
      .spi_cmd_ready(spi_cmd_ready),
      .core_cmd_valid(core_cmd_valid), .core_cmd_data(core_cmd_data),
      .core_cmd_src(core_cmd_src), .core_cmd_ready(core_cmd_ready),
      .halt(halt)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   typedef struct packed {
      logic [31:0] data;
      logic        src;
   } xfer_t;

   xfer_t       exp_q[$];
   logic [31:0] rd_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        cur_is_read = 1'b0;
   int          spi_left = 0;
   logic [31:0] spi_word = SPI0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] d, input logic s);
      xfer_t e;
      e.data = d;
      e.src  = s;
      exp_q.push_back(e);
   endtask

   // SPI source: presents spi_word while spi_left > 0, advances on each consumed word.
   initial begin
      logic tk;
      spi_cmd_valid = 1'b0;
      spi_cmd_data  = SPI0;
      forever begin
         @(negedge wb_clk_i);
         tk = spi_cmd_ready;
         @(posedge wb_clk_i);
         #1;
         if (tk) begin
            spi_left--;
            spi_word++;
         end
         spi_cmd_valid = (spi_left > 0);
         spi_cmd_data  = spi_word;
      end
   end

   // Monitor: pops the scoreboard on every core transfer and every read ack.
   always @(negedge wb_clk_i) begin
      if (resetn) begin
         if (core_cmd_valid && core_cmd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_xfer: got %h src %0d expected none", core_cmd_data, core_cmd_src);
            end else begin
               xfer_t e;
               e = exp_q.pop_front();
               chk("xfer_data", core_cmd_data, e.data);
               chk("xfer_src", {31'd0, core_cmd_src}, {31'd0, e.src});
            end
         end
         if (wbs_ack_o && cur_is_read) begin
            if (rd_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_read_ack: got %h expected none", wbs_dat_o);
            end else begin
               chk("wb_read", wbs_dat_o, rd_q.pop_front());
            end
         end
      end
   end

   task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                            input logic [3:0] sel, output logic acked);
      cur_is_read = ~we;
      wbs_adr_i = adr;
      wbs_we_i  = we;
      wbs_dat_i = dat;
      wbs_sel_i = sel;
      wbs_cyc_i = 1'b1;
      wbs_stb_i = 1'b1;
      acked = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge wb_clk_i);
         if (wbs_ack_o) begin
            acked = 1'b1;
            break;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic wb_write(input int unsigned off, input logic [31:0] dat, input logic [3:0] sel);
      logic a;
      wb_access(BASE + 32'(off * 4), 1'b1, dat, sel, a);
      if (!a) chk("wb_write_ack", {31'd0, a}, 32'd1);
   endtask

   task automatic wb_read(input int unsigned off, input logic [31:0] exp);
      logic a;
      rd_q.push_back(exp);
      wb_access(BASE + 32'(off * 4), 1'b0, '0, 4'hF, a);
      if (!a) begin
         void'(rd_q.pop_back());
         chk("wb_read_ack", {31'd0, a}, 32'd1);
      end
   endtask

   task automatic wait_drain(input int unsigned max_cycles);
      for (int unsigned i = 0; i < max_cycles && exp_q.size() != 0; i++)
         @(posedge wb_clk_i);
      #1;
      chk("drain_remaining", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge wb_clk_i);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"},       {31'd0, wbs_ack_o}, 32'd0);
      chk({tag, "_dat"},       wbs_dat_o, 32'd0);
      chk({tag, "_valid"},     {31'd0, core_cmd_valid}, 32'd0);
      chk({tag, "_data"},      core_cmd_data, 32'd0);
      chk({tag, "_src"},       {31'd0, core_cmd_src}, 32'd0);
      chk({tag, "_spi_ready"}, {31'd0, spi_cmd_ready}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      logic a;
      resetn = 1'b0;
      halt = 1'b0;
      core_cmd_ready = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
      #1;
      chk_reset_outputs("reset");
      repeat (2) @(posedge wb_clk_i);
      #1;
      resetn = 1'b1;

      // Reset register values: empty, last_src=1
      wb_read(1, 32'h0000_1100);
      wb_read(2, 32'h0000_0000);
      wb_read(3, 32'h0000_0000);

      // Single WB command, one-cycle load latency after the push edge
      core_cmd_ready = 1'b1;
      wb_write(2, 32'h1, 4'hF);
      push_exp(32'hA5A5_0001, 1'b0);
      wb_write(0, 32'hA5A5_0001, 4'hF);
      chk("latency_valid", {31'd0, core_cmd_valid}, 32'd1);
      chk("latency_data", core_cmd_data, 32'hA5A5_0001);
      wait_drain(20);
      wb_read(3, 32'h0000_0001);

      // Overflow with the arbiter disabled, then W1C
      wb_write(2, 32'h0, 4'hF);
      for (int i = 0; i < 9; i++) wb_write(0, 32'hB000_0000 + 32'(i), 4'hF);
      wb_read(1, 32'h0000_0608);
      wb_write(1, 32'h0000_0400, 4'hF);
      wb_read(1, 32'h0000_0208);

      // Flush, partial byte-select write, unmapped address
      wb_write(2, 32'h4, 4'hF);
      wb_read(1, 32'h0000_0100);
      wb_read(2, 32'h0000_0000);
      wb_write(0, 32'hDEAD_BEEF, 4'h3);
      wb_read(1, 32'h0000_0100);
      wb_access(BASE + 32'h10, 1'b1, 32'h1234_5678, 4'hF, a);
      chk("unmapped_ack", {31'd0, a}, 32'd0);

      // Push into a full FIFO on the same edge as a pop is accepted
      core_cmd_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_exp(32'hC000_0000 + 32'(i), 1'b0);
      for (int i = 0; i < 8; i++) wb_write(0, 32'hC000_0000 + 32'(i), 4'hF);
      wb_write(2, 32'h1, 4'hF);
      wb_write(0, 32'hC000_0008, 4'hF);
      core_cmd_ready = 1'b1;
      wb_write(0, 32'hC000_0009, 4'hF);
      wait_drain(50);
      wb_read(1, 32'h0000_0100);
      wb_read(3, 32'h0000_000B);
      wb_write(3, 32'h0, 4'hF);

      // Round-robin: last_src is WB here, so SPI takes the first tie
      wb_write(2, 32'h0, 4'hF);
      for (int i = 0; i < 3; i++) wb_write(0, 32'hD000_0000 + 32'(i), 4'hF);
      push_exp(SPI0 + 32'd0, 1'b1); push_exp(32'hD000_0000, 1'b0);
      push_exp(SPI0 + 32'd1, 1'b1); push_exp(32'hD000_0001, 1'b0);
      push_exp(SPI0 + 32'd2, 1'b1); push_exp(32'hD000_0002, 1'b0);
      for (int i = 3; i < 6; i++) push_exp(SPI0 + 32'(i), 1'b1);
      spi_left = 6;
      wb_write(2, 32'h1, 4'hF);
      wait_drain(100);
      wb_read(3, 32'h0006_0003);

      // SPI priority: WB starves while SPI is valid
      wb_write(3, 32'h0, 4'hF);
      wb_write(2, 32'h0, 4'hF);
      for (int i = 0; i < 3; i++) wb_write(0, 32'hE000_0000 + 32'(i), 4'hF);
      for (int i = 6; i < 26; i++) push_exp(SPI0 + 32'(i), 1'b1);
      for (int i = 0; i < 3; i++) push_exp(32'hE000_0000 + 32'(i), 1'b0);
      spi_left = 20;
      wb_write(2, 32'h3, 4'hF);
      wb_read(1, 32'h0000_3003);
      wait_drain(200);
      wb_read(3, 32'h0014_0003);

      // Backpressure: held command stays stable, SPI not consumed
      wb_write(2, 32'h1, 4'hF);
      core_cmd_ready = 1'b0;
      push_exp(32'hF100_0000, 1'b0);
      push_exp(SPI0 + 32'd26, 1'b1);
      wb_write(0, 32'hF100_0000, 4'hF);
      spi_left = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge wb_clk_i);
         chk("hold_valid", {31'd0, core_cmd_valid}, 32'd1);
         chk("hold_data", core_cmd_data, 32'hF100_0000);
         chk("hold_spi_ready", {31'd0, spi_cmd_ready}, 32'd0);
      end
      @(posedge wb_clk_i);
      #1;
      core_cmd_ready = 1'b1;
      wait_drain(50);

      // HALT aborts the held command and empties the FIFO
      core_cmd_ready = 1'b0;
      wb_write(2, 32'h0, 4'hF);
      for (int i = 0; i < 5; i++) wb_write(0, 32'hF200_0000 + 32'(i), 4'hF);
      wb_write(2, 32'h1, 4'hF);
      @(posedge wb_clk_i);
      #1;
      chk("prehalt_valid", {31'd0, core_cmd_valid}, 32'd1);
      halt = 1'b1;
      repeat (4) @(negedge wb_clk_i);
      chk("halt_valid", {31'd0, core_cmd_valid}, 32'd0);
      @(posedge wb_clk_i);
      #1;
      wb_read(1, 32'h0000_0900);
      halt = 1'b0;
      repeat (4) @(posedge wb_clk_i);
      #1;
      wb_read(1, 32'h0000_0100);

      // Asynchronous reset during a hold
      wb_write(0, 32'hF300_0000, 4'hF);
      @(posedge wb_clk_i);
      #1;
      chk("prereset_data", core_cmd_data, 32'hF300_0000);
      #3;
      resetn = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      @(posedge wb_clk_i);
      #1;
      resetn = 1'b1;
      wb_read(1, 32'h0000_1100);

      repeat (3) @(posedge wb_clk_i);
      #1;
      chk("final_exp_queue", 32'(exp_q.size()), 32'd0);
      chk("final_rd_queue", 32'(rd_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
